// File: rtl/cqf_slot_sched.sv
// CQF slot scheduler: derives a multi-slot ring index from precision_time with a
// runtime-programmable power-of-two slot period, flags slot boundaries and time
// discontinuities, and keeps boundary/resync statistics.
module cqf_slot_sched #(
  parameter int unsigned TIME_W    = 48,
  parameter int unsigned SUB_W     = 17,
  parameter int unsigned SUB_MOD   = 125000,
  parameter int unsigned SLOT_ID_W = 2,
  parameter int unsigned MIN_EXP   = 7,
  parameter int unsigned MAX_EXP   = 16,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [TIME_W-1:0]    precision_time,
  input  logic                 cfg_enable,
  input  logic                 cfg_wr,
  input  logic [4:0]           cfg_period_exp,
  input  logic                 cnt_clr,
  output logic [4:0]           active_exp,
  output logic                 cfg_err,
  output logic [SLOT_ID_W-1:0] slot_id,
  output logic                 slot_flag,
  output logic                 slot_start,
  output logic                 resync,
  output logic [CNT_W-1:0]     boundary_cnt,
  output logic [CNT_W-1:0]     resync_cnt
);

  localparam logic [31:0]      SubMod32 = 32'(SUB_MOD);
  localparam logic [4:0]       MinExp5  = 5'(MIN_EXP);
  localparam logic [4:0]       MaxExp5  = 5'(MAX_EXP);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  // Stage 1 / stage 2 state
  logic [31:0]          ticks_q, ticks_d;
  logic [31:0]          prev_idx_q, prev_idx_d;
  logic [SLOT_ID_W-1:0] slot_id_q, slot_id_d;
  logic                 slot_start_q, slot_start_d;
  logic                 resync_q, resync_d;
  logic                 rearm_q, rearm_d;

  // Configuration state
  logic [4:0]           active_exp_q, active_exp_d;
  logic [4:0]           pend_q, pend_d;
  logic                 pend_vld_q, pend_vld_d;
  logic                 cfg_err_q, cfg_err_d;

  // Statistics
  logic [CNT_W-1:0]     bnd_cnt_q, bnd_cnt_d;
  logic [CNT_W-1:0]     rsy_cnt_q, rsy_cnt_d;

  logic [31:0] up32, lo32, ticks_c;
  logic [31:0] idx_c, idx_mask, idx_diff;
  logic        is_same, is_step, exp_legal;

  // Ticks are only needed modulo 2**32, so the whole product is done in 32 bits.
  assign up32    = 32'(precision_time[TIME_W-1:SUB_W]);
  assign lo32    = 32'(precision_time[SUB_W-1:0]);
  assign ticks_c = up32 * SubMod32 + lo32;

  assign idx_c    = ticks_q >> active_exp_q;
  // The index only spans 32-exp bits, so a ticks wrap is a +1 step modulo that range.
  assign idx_mask = 32'hFFFF_FFFF >> active_exp_q;
  assign idx_diff = (idx_c - prev_idx_q) & idx_mask;
  assign is_same  = (idx_c == prev_idx_q);
  assign is_step  = (idx_diff == 32'd1);

  assign exp_legal = (cfg_period_exp >= MinExp5) && (cfg_period_exp <= MaxExp5);

  // Next-state: boundary/resync detection, exponent switching, config and counters.
  always_comb begin
    ticks_d      = ticks_c;
    prev_idx_d   = idx_c;
    slot_id_d    = slot_id_q;
    slot_start_d = 1'b0;
    resync_d     = 1'b0;
    rearm_d      = 1'b0;
    active_exp_d = active_exp_q;
    pend_d       = pend_q;
    pend_vld_d   = pend_vld_q;
    cfg_err_d    = 1'b0;
    bnd_cnt_d    = bnd_cnt_q;
    rsy_cnt_d    = rsy_cnt_q;

    if (!cfg_enable) begin
      // Idle: outputs low, and the first enabled cycle re-arms from scratch.
      slot_id_d = '0;
      rearm_d   = 1'b1;
    end else if (rearm_q) begin
      slot_id_d = idx_c[SLOT_ID_W-1:0];
    end else if (!is_same) begin
      slot_id_d    = idx_c[SLOT_ID_W-1:0];
      slot_start_d = 1'b1;
      resync_d     = !is_step;
      bnd_cnt_d    = bnd_cnt_q + CntOne;
      if (!is_step) begin
        rsy_cnt_d = rsy_cnt_q + CntOne;
      end
      // New exponent takes effect here; next cycle's index is on a new scale.
      if (pend_vld_q) begin
        active_exp_d = pend_q;
        pend_vld_d   = 1'b0;
        rearm_d      = 1'b1;
      end
    end

    // A write landing with a boundary stays pending for the next one.
    if (cfg_wr) begin
      if (exp_legal) begin
        pend_d     = cfg_period_exp;
        pend_vld_d = 1'b1;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    if (cnt_clr) begin
      bnd_cnt_d = '0;
      rsy_cnt_d = '0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ticks_q      <= '0;
      prev_idx_q   <= '0;
      slot_id_q    <= '0;
      slot_start_q <= 1'b0;
      resync_q     <= 1'b0;
      rearm_q      <= 1'b0;
      active_exp_q <= MinExp5;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      cfg_err_q    <= 1'b0;
      bnd_cnt_q    <= '0;
      rsy_cnt_q    <= '0;
    end else begin
      ticks_q      <= ticks_d;
      prev_idx_q   <= prev_idx_d;
      slot_id_q    <= slot_id_d;
      slot_start_q <= slot_start_d;
      resync_q     <= resync_d;
      rearm_q      <= rearm_d;
      active_exp_q <= active_exp_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      cfg_err_q    <= cfg_err_d;
      bnd_cnt_q    <= bnd_cnt_d;
      rsy_cnt_q    <= rsy_cnt_d;
    end
  end

  assign active_exp   = active_exp_q;
  assign cfg_err      = cfg_err_q;
  assign slot_id      = slot_id_q;
  assign slot_flag    = slot_id_q[0];
  assign slot_start   = slot_start_q;
  assign resync       = resync_q;
  assign boundary_cnt = bnd_cnt_q;
  assign resync_cnt   = rsy_cnt_q;

endmodule
